// File: rtl/clk_div_prog.sv
// Programmable CPU/memory clock divider with glitch-free halt/run and single-step.
// Optional rising-edge counter on cyc_cnt when CLK_DIV_PROG_CYCLE_CNT_EN is defined.
module clk_div_prog #(
  parameter int CNT_W        = 24,
  parameter int DEFAULT_HALF = 10000,
  parameter int START_RUN    = 1
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [CNT_W-1:0] div_half,
  input  logic             div_load,
  input  logic             run_en,
  input  logic             step,
  output logic             clk,
  output logic             mem_clk,
  output logic             tick,
  output logic             div_pending,
  output logic             halted,
  output logic [31:0]      cyc_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam state_t       RESET_STATE = (START_RUN != 0) ? S_RUN : S_HALT;
  localparam [CNT_W-1:0]   RESET_HALF  = CNT_W'(DEFAULT_HALF);
  localparam [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_nxt;
  logic [CNT_W-1:0] half_r;
  logic [CNT_W-1:0] half_nxt;
  logic [CNT_W-1:0] pend_r;
  logic [CNT_W-1:0] pend_nxt;
  logic             pend_vld;
  logic             pend_vld_nxt;
  logic             clk_nxt;
  logic             tick_nxt;
  logic             boundary;
  logic             toggle;

  // >= rather than == so a shrunk ratio can never leave the counter stranded
  assign toggle = (counter >= half_r);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      counter  <= '0;
      half_r   <= RESET_HALF;
      pend_r   <= '0;
      pend_vld <= 1'b0;
      clk      <= 1'b0;
      mem_clk  <= 1'b1;
      tick     <= 1'b0;
    end else begin
      state    <= state_nxt;
      counter  <= counter_nxt;
      half_r   <= half_nxt;
      pend_r   <= pend_nxt;
      pend_vld <= pend_vld_nxt;
      clk      <= clk_nxt;
      mem_clk  <= ~clk_nxt;
      tick     <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    clk_nxt     = clk;
    tick_nxt    = 1'b0;
    boundary    = 1'b0;

    case (state)
      S_RUN: begin
        if (toggle) begin
          counter_nxt = '0;
          boundary    = clk;
          if (!run_en) begin
            // falling edge completes the high phase; a rising edge is suppressed
            clk_nxt   = 1'b0;
            state_nxt = S_HALT;
          end else begin
            clk_nxt  = ~clk;
            tick_nxt = ~clk;
          end
        end else begin
          counter_nxt = counter + CNT_ONE;
        end
      end

      S_HALT: begin
        clk_nxt     = 1'b0;
        counter_nxt = '0;
        boundary    = 1'b1;
        if (run_en) begin
          state_nxt = S_RUN;
        end else if (step) begin
          state_nxt = S_STEP;
        end
      end

      S_STEP: begin
        if (toggle) begin
          counter_nxt = '0;
          clk_nxt     = ~clk;
          tick_nxt    = ~clk;
          if (clk) begin
            boundary  = 1'b1;
            state_nxt = S_HALT;
          end
        end else begin
          counter_nxt = counter + CNT_ONE;
        end
      end

      default: begin
        clk_nxt     = 1'b0;
        counter_nxt = '0;
        state_nxt   = S_HALT;
      end
    endcase
  end

  always_comb begin
    half_nxt     = half_r;
    pend_nxt     = pend_r;
    pend_vld_nxt = pend_vld;

    if (div_load) begin
      pend_nxt = div_half;
    end

    // a load coinciding with a boundary bypasses the pending register
    if (boundary) begin
      if (div_load) begin
        half_nxt = div_half;
      end else if (pend_vld) begin
        half_nxt = pend_r;
      end
      pend_vld_nxt = 1'b0;
    end else if (div_load) begin
      pend_vld_nxt = 1'b1;
    end
  end

  assign div_pending = pend_vld;
  assign halted      = (state == S_HALT);

`ifdef CLK_DIV_PROG_CYCLE_CNT_EN
  logic [31:0] cyc_r;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cyc_r <= 32'd0;
    end else if (tick_nxt) begin
      cyc_r <= cyc_r + 32'd1;
    end
  end

  assign cyc_cnt = cyc_r;
`else
  assign cyc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed vector table, phase-countdown reference model
// under random stimulus, and hand sequences for reset and divide-by-2.
`timescale 1ns/1ps
module tb_clk_div_prog;
  localparam int CNT_W = 8;
  localparam int DH    = 3;
  localparam int ST_RUN = 0, ST_HALT = 1, ST_STEP = 2;

  logic             clkin = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] div_half = '0;
  logic             div_load = 1'b0;
  logic             run_en = 1'b1;
  logic             step = 1'b0;
  logic             clk, mem_clk, tick, div_pending, halted;
  logic [31:0]      cyc_cnt;

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_HALF(DH), .START_RUN(1)) dut (
    .clkin(clkin), .reset(reset), .div_half(div_half), .div_load(div_load),
    .run_en(run_en), .step(step), .clk(clk), .mem_clk(mem_clk), .tick(tick),
    .div_pending(div_pending), .halted(halted), .cyc_cnt(cyc_cnt)
  );

  always #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each clk phase lasts half+1 cycles; m_left counts down what remains.
  int          m_st;
  bit          m_clk, m_tick, m_pv;
  int          m_left, m_half, m_pend;
  int unsigned m_cyc;

  typedef struct {
    bit r; bit s; bit l; logic [CNT_W-1:0] d;
    bit e_clk; bit e_tick; bit e_pend; bit e_halt;
  } vec_t;
  vec_t tbl[23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_RUN; m_clk = 0; m_tick = 0; m_pv = 0;
    m_half = DH; m_pend = 0; m_left = DH + 1; m_cyc = 0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit l, input int d);
    bit bnd;
    bit ev;
    bnd = 0; ev = 0; m_tick = 0;
    case (m_st)
      ST_RUN: begin
        m_left--;
        if (m_left == 0) begin
          ev = 1; bnd = m_clk;
          if (!r) begin m_clk = 0; m_st = ST_HALT; end
          else begin m_clk = !m_clk; m_tick = m_clk; end
        end
      end
      ST_STEP: begin
        m_left--;
        if (m_left == 0) begin
          ev = 1;
          if (m_clk) begin m_clk = 0; bnd = 1; m_st = ST_HALT; end
          else begin m_clk = 1; m_tick = 1; end
        end
      end
      default: begin
        ev = 1; bnd = 1; m_clk = 0;
        if (r) m_st = ST_RUN;
        else if (s) m_st = ST_STEP;
      end
    endcase
    if (l) m_pend = d;
    if (bnd) begin
      if (l) m_half = d;
      else if (m_pv) m_half = m_pend;
      m_pv = 0;
    end else if (l) begin
      m_pv = 1;
    end
    if (ev) m_left = m_half + 1;
    if (m_tick) m_cyc++;
  endtask

  function automatic logic [31:0] exp_cyc();
`ifdef CLK_DIV_PROG_CYCLE_CNT_EN
    return m_cyc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_model();
    check("mdl_clk", clk, m_clk);
    check("mdl_mem_clk", mem_clk, !m_clk);
    check("mdl_tick", tick, m_tick);
    check("mdl_pending", div_pending, m_pv);
    check("mdl_halted", halted, m_st == ST_HALT);
    check("mdl_cyc_cnt", cyc_cnt, exp_cyc());
  endtask

  task automatic cycle(input bit r, input bit s, input bit l, input logic [CNT_W-1:0] d);
    run_en = r; step = s; div_load = l; div_half = d;
    @(posedge clkin);
    model_edge(r, s, l, int'(d));
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] c0;
    bit          r_lvl;

    //          r  s  l  d    clk tick pend halt
    tbl[0]  = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[1]  = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[2]  = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[3]  = '{1, 0, 0, 0,   1,  1,   0,   0};
    tbl[4]  = '{1, 0, 1, 1,   1,  0,   1,   0};
    tbl[5]  = '{1, 0, 0, 0,   1,  0,   1,   0};
    tbl[6]  = '{1, 0, 0, 0,   1,  0,   1,   0};
    tbl[7]  = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[8]  = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[9]  = '{1, 0, 0, 0,   1,  1,   0,   0};
    tbl[10] = '{1, 0, 0, 0,   1,  0,   0,   0};
    tbl[11] = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[12] = '{0, 0, 0, 0,   0,  0,   0,   0};
    tbl[13] = '{0, 0, 0, 0,   0,  0,   0,   1};
    tbl[14] = '{0, 1, 0, 0,   0,  0,   0,   0};
    tbl[15] = '{0, 0, 0, 0,   0,  0,   0,   0};
    tbl[16] = '{0, 0, 0, 0,   1,  1,   0,   0};
    tbl[17] = '{0, 1, 0, 0,   1,  0,   0,   0};
    tbl[18] = '{0, 0, 0, 0,   0,  0,   0,   1};
    tbl[19] = '{0, 0, 0, 0,   0,  0,   0,   1};
    tbl[20] = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[21] = '{1, 0, 0, 0,   0,  0,   0,   0};
    tbl[22] = '{1, 0, 0, 0,   1,  1,   0,   0};

    model_reset();
    #12;
    check("rst_clk", clk, 1'b0);
    check("rst_mem_clk", mem_clk, 1'b1);
    check("rst_tick", tick, 1'b0);
    check("rst_pending", div_pending, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cyc_cnt", cyc_cnt, 32'd0);
    @(negedge clkin);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].d);
      check($sformatf("tbl%0d_clk", i), clk, tbl[i].e_clk);
      check($sformatf("tbl%0d_mem_clk", i), mem_clk, !tbl[i].e_clk);
      check($sformatf("tbl%0d_tick", i), tick, tbl[i].e_tick);
      check($sformatf("tbl%0d_pending", i), div_pending, tbl[i].e_pend);
      check($sformatf("tbl%0d_halted", i), halted, tbl[i].e_halt);
    end

    r_lvl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) r_lvl = !r_lvl;
      cycle(r_lvl, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
            CNT_W'($urandom_range(0, 5)));
    end

    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_clk", clk, 1'b0);
    check("midrst_mem_clk", mem_clk, 1'b1);
    check("midrst_tick", tick, 1'b0);
    check("midrst_pending", div_pending, 1'b0);
    check("midrst_halted", halted, 1'b0);
    check("midrst_cyc_cnt", cyc_cnt, 32'd0);
    model_reset();
    @(negedge clkin);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    check("midrst_low3", clk, 1'b0);
    cycle(1, 0, 0, 0);
    check("midrst_rise4", tick, 1'b1);

    cycle(1, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    c0 = cyc_cnt;
    for (int i = 0; i < 100; i++) cycle(1, 0, 0, 0);
`ifdef CLK_DIV_PROG_CYCLE_CNT_EN
    check("div2_cyc_delta", (cyc_cnt - c0 >= 49) && (cyc_cnt - c0 <= 51), 1'b1);
`else
    check("div2_cyc_zero", cyc_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
